// File: rtl/lms_pkg.sv
// Shared types and default parameters for the LMS tap-update sequencer.
package lms_pkg;

  localparam int N_DEF     = 8;
  localparam int W_DEF     = 10;
  localparam int MU_SH_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Control word held for the duration of one update.
  typedef struct packed {
    logic [2:0] code;
    logic       sg;
  } cw_t;

endpackage

// File: rtl/lms_tap_sched_if.sv
// Control handshake plus tap/weight memory bus of lms_tap_sched.
interface lms_tap_sched_if
  import lms_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int AW = $clog2(N_DEF)
);

  logic                 start;
  logic [2:0]           cw_s;
  logic                 cw_sg;
  logic                 cw_nz;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic signed [W-1:0]  x_rd;
  logic signed [W-1:0]  w_rd;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic signed [W-1:0]  w_wr;

  // master: the environment issuing updates and serving the memories.
  modport master (
    output start, cw_s, cw_sg, cw_nz, x_rd, w_rd,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, w_wr
  );

  // slave: the sequencer itself.
  modport slave (
    input  start, cw_s, cw_sg, cw_nz, x_rd, w_rd,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, w_wr
  );

endinterface

// File: rtl/lms_tap_sched_tap_update.sv
// Per-tap weight update: w +/- (x >>> (MU_SH + code - 1)), saturated to W bits.
module tap_update
  import lms_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int MU_SH = MU_SH_DEF
) (
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] w_i,
  input  logic [2:0]          code_i,
  input  logic                sg_i,
  output logic signed [W-1:0] w_o
);

  logic [7:0]          sh;
  logic signed [W-1:0] d;
  logic signed [W:0]   sum;

  always_comb begin
    sh = 8'(MU_SH) + 8'(code_i) - 8'd1;
    if (sh >= 8'(W)) d = {W{x_i[W-1]}};
    else             d = x_i >>> sh;

    // One guard bit is enough for a single add/subtract of two W-bit values.
    if (sg_i) sum = {w_i[W-1], w_i} - {d[W-1], d};
    else      sum = {w_i[W-1], w_i} + {d[W-1], d};

    if (sum[W] != sum[W-1]) w_o = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else                    w_o = sum[W-1:0];
  end

endmodule

// File: rtl/lms_tap_sched.sv
// Sequences a read / write-back pass over N taps applying one LMS weight update.
module lms_tap_sched
  import lms_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int MU_SH = MU_SH_DEF,
  parameter int AW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  lms_tap_sched_if.slave  bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  cw_t           cw_q, cw_d;
  logic signed [W-1:0] w_new;

  // NOTE: sequential state uses non-blocking assignments so every register updates together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      cw_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cw_q    <= cw_d;
    end
  end

  // NOTE: every variable gets a default first so no path leaves one unassigned (no inferred latches).
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cw_d    = cw_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          cw_d    = '{code: bus.cw_s, sg: bus.cw_sg};
          k_d     = '0;
          state_d = (bus.cw_nz && bus.cw_s != 3'd0) ? RD : DONE;
        end
      end
      RD: state_d = WB;
      WB: begin
        if (k_q == AW'(N - 1)) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // wr_en is cut combinationally by rst so a reset in WB suppresses that edge's write.
  always_comb begin
    bus.busy    = (state_q != IDLE);
    bus.done    = (state_q == DONE);
    bus.rd_en   = (state_q == RD);
    bus.rd_addr = k_q;
    bus.wr_en   = (state_q == WB) && !rst;
    bus.wr_addr = k_q;
    bus.w_wr    = w_new;
  end

  tap_update #(
    .W     (W),
    .MU_SH (MU_SH)
  ) u_tap_update (
    .x_i    (bus.x_rd),
    .w_i    (bus.w_rd),
    .code_i (cw_q.code),
    .sg_i   (cw_q.sg),
    .w_o    (w_new)
  );

endmodule

// File: tb/tb_lms_tap_sched.sv
// Self-checking bench for lms_tap_sched: directed and random updates against an arithmetic model.
module tb_lms_tap_sched;

  localparam int N  = 8;
  localparam int W  = 10;
  localparam int MU = 2;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lms_tap_sched_if #(.W(W), .AW(AW)) bus ();

  lms_tap_sched #(.N(N), .W(W), .MU_SH(MU), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Tap-sample and weight memories with one-cycle read latency.
  logic signed [W-1:0] xmem [N];
  logic signed [W-1:0] wmem [N];
  int  x_init [N];
  int  w_init [N];
  int  exp_w  [N];
  logic load = 1'b0;
  int  rd_cnt = 0;
  int  wr_cnt = 0;
  int  proto_err = 0;
  logic prev_rd = 1'b0;
  logic prev_done = 1'b0;
  logic [AW-1:0] prev_rd_addr = '0;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++) begin
        xmem[i] <= W'(x_init[i]);
        wmem[i] <= W'(w_init[i]);
      end
      rd_cnt <= 0;
      wr_cnt <= 0;
    end else begin
      if (bus.rd_en) begin
        bus.x_rd <= xmem[bus.rd_addr];
        bus.w_rd <= wmem[bus.rd_addr];
        rd_cnt   <= rd_cnt + 1;
      end
      if (bus.wr_en) begin
        wmem[bus.wr_addr] <= bus.w_wr;
        wr_cnt <= wr_cnt + 1;
      end
    end
    if (bus.rd_en && bus.wr_en) proto_err <= proto_err + 1;
    else if (bus.wr_en && !(prev_rd && prev_rd_addr == bus.wr_addr)) proto_err <= proto_err + 1;
    else if (bus.done && prev_done) proto_err <= proto_err + 1;
    prev_rd      <= bus.rd_en;
    prev_rd_addr <= bus.rd_addr;
    prev_done    <= bus.done;
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: step is x scaled by 2^-(MU+code-1) rounded toward minus infinity, then clamp.
  function automatic int ref_tap(int x, int w, int code, bit sg);
    int p, d, r;
    p = 1 << (MU + code - 1);
    d = (x >= 0) ? x / p : -((-x + p - 1) / p);
    r = sg ? w - d : w + d;
    if (r > 511)  r = 511;
    if (r < -512) r = -512;
    return r;
  endfunction

  task automatic model_update(input int code, input bit sg, input bit nz, input int upto);
    if (nz && code != 0)
      for (int i = 0; i < upto; i++) exp_w[i] = ref_tap(x_init[i], exp_w[i], code, sg);
  endtask

  task automatic commit_load();
    for (int i = 0; i < N; i++) exp_w[i] = w_init[i];
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic fill(input int x, input int w);
    for (int i = 0; i < N; i++) begin x_init[i] = x; w_init[i] = w; end
    commit_load();
  endtask

  task automatic check_weights(input string tag);
    for (int i = 0; i < N; i++) check($sformatf("%s_w%0d", tag, i), 32'(wmem[i]), exp_w[i]);
  endtask

  // Pulses start in the next cycle and returns the start-to-done latency in cycles.
  task automatic run_update(input logic [2:0] code, input logic sg, input logic nz,
                            input bit repulse, output int lat);
    bit seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.cw_s = code; bus.cw_sg = sg; bus.cw_nz = nz;
    lat = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 1);
      end
      if (repulse && lat == 4) begin
        bus.start = 1'b1; bus.cw_s = 3'd7; bus.cw_sg = ~sg; bus.cw_nz = 1'b1;
      end
      if (repulse && lat == 5) bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  int lat;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.cw_s = '0; bus.cw_sg = 1'b0; bus.cw_nz = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(bus.busy),  0);
    check("rst_done",  32'(bus.done),  0);
    check("rst_rd_en", 32'(bus.rd_en), 0);
    check("rst_wr_en", 32'(bus.wr_en), 0);
    rst = 1'b0;

    // x=64, w=0, code 1: each weight becomes 16, done in cycle 17.
    fill(64, 0);
    run_update(3'd1, 1'b0, 1'b1, 1'b0, lat);
    model_update(1, 1'b0, 1'b1, N);
    check("basic_latency", lat, 17);
    @(negedge clk);
    check("basic_rd_cnt", rd_cnt, 8);
    check("basic_wr_cnt", wr_cnt, 8);
    check("basic_w0_16", 32'(wmem[0]), 16);
    check_weights("basic");

    // Negative sample, subtract: d=-8, 10 -> 18.
    fill(-128, 10);
    run_update(3'd3, 1'b1, 1'b1, 1'b0, lat);
    model_update(3, 1'b1, 1'b1, N);
    @(negedge clk);
    check("neg_w5_18", 32'(wmem[5]), 18);
    check_weights("neg");

    // Saturation at both rails.
    fill(511, 500);
    run_update(3'd1, 1'b0, 1'b1, 1'b0, lat);
    model_update(1, 1'b0, 1'b1, N);
    @(negedge clk);
    check("sat_hi", 32'(wmem[2]), 511);
    check_weights("sat_hi");
    fill(511, -510);
    run_update(3'd1, 1'b1, 1'b1, 1'b0, lat);
    model_update(1, 1'b1, 1'b1, N);
    @(negedge clk);
    check("sat_lo", 32'(wmem[7]), -512);
    check_weights("sat_lo");

    // Zero control words: immediate done, no memory traffic.
    fill(100, 33);
    run_update(3'd2, 1'b0, 1'b0, 1'b0, lat);
    check("nz0_latency", lat, 1);
    run_update(3'd0, 1'b1, 1'b1, 1'b0, lat);
    check("code0_latency", lat, 1);
    @(negedge clk);
    check("zero_rd_cnt", rd_cnt, 0);
    check("zero_wr_cnt", wr_cnt, 0);
    check_weights("zero");

    // Start re-pulsed while busy is ignored; then a back-to-back update.
    for (int i = 0; i < N; i++) begin x_init[i] = 40 * i - 150; w_init[i] = 7 * i; end
    commit_load();
    run_update(3'd2, 1'b0, 1'b1, 1'b1, lat);
    model_update(2, 1'b0, 1'b1, N);
    check("repulse_latency", lat, 17);
    check("repulse_wr_cnt", wr_cnt, 8);
    run_update(3'd1, 1'b1, 1'b1, 1'b0, lat);
    model_update(1, 1'b1, 1'b1, N);
    check("b2b_latency", lat, 17);
    @(negedge clk);
    check("b2b_wr_cnt", wr_cnt, 16);
    check_weights("b2b");

    // Random updates.
    for (int r = 0; r < 6; r++) begin
      int code;
      bit sg;
      for (int i = 0; i < N; i++) begin
        x_init[i] = int'($urandom_range(1023)) - 512;
        w_init[i] = int'($urandom_range(1023)) - 512;
      end
      commit_load();
      code = int'($urandom_range(7, 1));
      sg   = 1'($urandom_range(1));
      run_update(3'(code), sg, 1'b1, 1'b0, lat);
      model_update(code, sg, 1'b1, N);
      check($sformatf("rand%0d_latency", r), lat, 17);
      @(negedge clk);
      check_weights($sformatf("rand%0d", r));
    end

    // Reset during WB of tap 3: taps 0-2 updated, the rest untouched.
    for (int i = 0; i < N; i++) begin x_init[i] = 200 + i; w_init[i] = -3 * i; end
    commit_load();
    @(negedge clk);
    bus.start = 1'b1; bus.cw_s = 3'd1; bus.cw_sg = 1'b0; bus.cw_nz = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    check("mid_wr_en_k3", 32'(bus.wr_en), 1);
    check("mid_wr_addr", 32'(bus.wr_addr), 3);
    rst = 1'b1;
    #1;
    check("mid_wr_cut", 32'(bus.wr_en), 0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_idle_busy", 32'(bus.busy), 0);
    check("mid_idle_rd_en", 32'(bus.rd_en), 0);
    model_update(1, 1'b0, 1'b1, 3);
    @(negedge clk);
    check("mid_busy_stays", 32'(bus.busy), 0);
    check_weights("mid");

    // Reset wins over start in the same cycle.
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.cw_s = 3'd1; bus.cw_nz = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    check("prio_busy", 32'(bus.busy), 0);
    @(negedge clk);
    check("prio_busy_next", 32'(bus.busy), 0);
    check("prio_done", 32'(bus.done), 0);

    check("protocol_errors", proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
